pi_request_queue: RTL
=====================

PI_REQUEST_QUEUE -- requirements
Module: pi_request_queue

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, request entries held; power of two, 2..8.
REQ-002 Parameter: SYNC_STAGES, default 2, flops on the asynchronous PI_WR input.
REQ-003 sys_clk  in  1  system clock from the PLL; the only clock. Reset is synchronous and active-high.
REQ-004 sys_rst  in  1  synchronous active-high reset.
REQ-005 pi_wr  in  1  raw Pi write strobe, asynchronous, active-low.
REQ-006 pi_a  in  3  Pi register address, stable while pi_wr is low.
REQ-007 pi_data_in  in  16  Pi write data, stable while pi_wr is low.
REQ-008 req_valid  out  1  head FIFO entry available to the bus engine.
REQ-009 req_ready  in  1  bus engine accepts the head entry.
REQ-010 req_addr  out  24, req_size  out  2, req_read  out  1, req_fc  out  3, req_wdata  out  32  head entry fields.
REQ-011 done_valid  in  1  one-cycle pulse when the bus engine finishes an accepted entry.
REQ-012 done_rdata  in  32, done_ok  in  1  read data and normal-termination flag, qualified by done_valid.
REQ-013 rdata  out  32  last completed read data; pi_control  out  15  control bits.
REQ-014 pi_req_active  out  1, fifo_count  out  4, overflow  out  1  Pi status.

Function
REQ-015 pi_wr passes through SYNC_STAGES flops; a registered wr_strobe pulses for one cycle when the two oldest stages read 1 then 0 (falling edge).
REQ-016 A register update becomes visible on the second sys_clk edge after wr_strobe asserts.
REQ-017 Decode on wr_strobe: pi_a 0 loads wdata[15:0]; pi_a 1 loads wdata[31:16]; pi_a 2 loads addr[15:0].
REQ-018 pi_a 3 loads addr[23:16]=d[7:0], size=d[9:8], read=d[10], fc=d[13:11], and pushes the staging registers into the FIFO in the same cycle.
REQ-019 pi_a 4 with d[15]=1 ORs d[14:0] into pi_control; with d[15]=0 it clears the bits set in d[14:0]. pi_a 5..7 writes are ignored.
REQ-020 Staging registers keep their values after a push, so the Pi can re-issue a request by writing only the changed fields.
REQ-021 The FIFO is first-word-fall-through: req_valid=1 whenever fifo_count>0, and the outputs show the head entry.
REQ-022 A pop occurs on a cycle with req_valid and req_ready both high. Outputs advance on the next edge.
REQ-023 A push to a full FIFO is dropped and sets sticky overflow, unless a pop happens in the same cycle; in that case both are performed and the count is unchanged.
REQ-024 Simultaneous push and pop on a non-empty FIFO leaves fifo_count unchanged. A push into an empty FIFO gives req_valid=1 on the next cycle.
REQ-025 An outstanding counter increments on a pop and decrements on done_valid; a pop and done_valid in the same cycle leave it unchanged.
REQ-026 When done_valid=1 and the completed entry was a read (tracked per outstanding entry), rdata is loaded with done_rdata.
REQ-027 The done_ok flag of the last completion is kept and exposed through pi_control-independent status bit 15 of rdata's companion: it goes to bit 0 of an internal status register, not driven externally.
REQ-028 pi_req_active = (fifo_count!=0) or (outstanding!=0).
REQ-029 A control write with d[15]=0 and d[14]=1 clears overflow.

Reset
REQ-030 While sys_rst=1 the module SHALL hold: FIFO empty, req_valid=0, outstanding=0, overflow=0, pi_control=0, rdata=0, staging=0, sync flops=1 (idle high).
REQ-031 A reset in the middle of an operation discards all queued and outstanding entries. done_valid pulses during reset and on the first cycle after it are ignored.

Configuration
REQ-032 Macro PI_POSTED_WRITE_EN.
REQ-033 With PI_POSTED_WRITE_EN defined, writes pop without waiting, and the bus engine may have up to FIFO_DEPTH entries outstanding.
REQ-034 Without PI_POSTED_WRITE_EN, req_valid is gated by outstanding==0, so at most one entry is outstanding and every access is non-posted.

Structure
REQ-035 A shared package pi_bus_pkg holds the register addresses (0..4,7), the request entry struct {fc, read, size, addr, wdata}, and the control-bit indices.
REQ-036 There is one sub-module, pi_req_fifo: a parameterised FWFT FIFO with a count output and a simultaneous push/pop rule.

Verification
REQ-037 Write addr 0x00BEEF, then pi_a 3 with d=0x0501 (8-bit read, fc=0): after the edge, req_valid=1, req_addr=0x01BEEF, req_read=1, req_size=1.
REQ-038 Fill 4 entries with req_ready=0, then push a 5th: fifo_count=4, overflow=1; a control write 0x4000 clears overflow.
REQ-039 Full FIFO with req_ready=1 in the same cycle as a push: fifo_count stays 4, no overflow, order is preserved.
REQ-040 Read completes with done_rdata=0x12345678: rdata=0x12345678 on the next cycle; pi_req_active falls to 0 once the FIFO is empty.
REQ-041 Without PI_POSTED_WRITE_EN: two queued writes, req_ready=1; the second req_valid stays low until done_valid for the first.
REQ-042 Assert sys_rst with 3 entries queued and 1 outstanding: all counters are 0 and req_valid=0; a done_valid pulse after reset does not underflow the outstanding counter.

Source files
------------

// File: rtl/pi_bus_pkg.sv
// Shared definitions for the Pi request queue: register map, request entry layout
// and control-word bit positions.
package pi_bus_pkg;

    typedef enum logic [2:0] {
        PI_REG_WDATA_LO = 3'd0,
        PI_REG_WDATA_HI = 3'd1,
        PI_REG_ADDR_LO  = 3'd2,
        PI_REG_ADDR_HI  = 3'd3,
        PI_REG_CTRL     = 3'd4,
        PI_REG_RSVD     = 3'd7
    } pi_reg_e;

    typedef struct packed {
        logic [2:0]  fc;
        logic        read;
        logic [1:0]  size;
        logic [23:0] addr;
        logic [31:0] wdata;
    } req_entry_t;

    localparam int CTRL_SET_BIT     = 15;
    localparam int CTRL_OVF_CLR_BIT = 14;

    // Set/clear write: the top bit selects OR-in versus clear-where-set.
    function automatic logic [14:0] ctrl_update(input logic [14:0] cur, input logic [15:0] d);
        if (d[CTRL_SET_BIT]) begin
            return cur | d[14:0];
        end
        return cur & ~d[14:0];
    endfunction

endpackage

// File: rtl/pi_req_fifo.sv
// First-word-fall-through request FIFO with occupancy count; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module pi_req_fifo
    import pi_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  req_entry_t push_data,
    input  logic       pop,
    output req_entry_t head,
    output logic [3:0] count
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    req_entry_t       mem_q [DEPTH];
    req_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 4'd0);
        do_push  = push && ((count_q != DEPTH_C) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {3'd0, do_push} - {3'd0, do_pop};
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 4'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pi_request_queue.sv
// Pi write-port request queue: synchronises the Pi strobe, stages bus requests and
// feeds them to the bus engine. Optional macro PI_POSTED_WRITE_EN enables posted writes.
module pi_request_queue
    import pi_bus_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pi_wr,
    input  logic [2:0]  pi_a,
    input  logic [15:0] pi_data_in,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [23:0] req_addr,
    output logic [1:0]  req_size,
    output logic        req_read,
    output logic [2:0]  req_fc,
    output logic [31:0] req_wdata,
    input  logic        done_valid,
    input  logic [31:0] done_rdata,
    input  logic        done_ok,
    output logic [31:0] rdata,
    output logic [14:0] pi_control,
    output logic        pi_req_active,
    output logic [3:0]  fifo_count,
    output logic        overflow
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   cmd_vld_q, cmd_vld_d;
    logic [2:0]             cmd_a_q, cmd_a_d;
    logic [15:0]            cmd_data_q, cmd_data_d;
    req_entry_t             stage_q, stage_d;
    logic [14:0]            ctrl_q, ctrl_d;
    logic                   ovf_q, ovf_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   done_ok_q, done_ok_d;
    logic                   first_q, first_d;
    logic [3:0]             out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]       out_wp_q, out_wp_d;
    logic [PTR_W-1:0]       out_rp_q, out_rp_d;
    logic [FIFO_DEPTH-1:0]  out_rd_q, out_rd_d;

    logic       push, pop, fifo_full, done_en;
    req_entry_t fifo_head;
    logic [3:0] fifo_cnt;

    pi_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push),
        .push_data (stage_d),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    // Falling edge of the synchronised strobe, then a one-cycle command capture.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], pi_wr};
        wr_strobe_d = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
        cmd_vld_d   = wr_strobe_q;
        cmd_a_d     = wr_strobe_q ? pi_a : cmd_a_q;
        cmd_data_d  = wr_strobe_q ? pi_data_in : cmd_data_q;
    end

    assign fifo_full = (fifo_cnt == DEPTH_C);

    always_comb begin
`ifdef PI_POSTED_WRITE_EN
        req_valid = (fifo_cnt != 4'd0) && (out_cnt_q < DEPTH_C) &&
                    (!fifo_head.read || (out_cnt_q == 4'd0));
`else
        req_valid = (fifo_cnt != 4'd0) && (out_cnt_q == 4'd0);
`endif
        pop = req_valid && req_ready;
    end

    always_comb begin
        stage_d = stage_q;
        ctrl_d  = ctrl_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        if (cmd_vld_q) begin
            case (cmd_a_q)
                PI_REG_WDATA_LO: stage_d.wdata[15:0]  = cmd_data_q;
                PI_REG_WDATA_HI: stage_d.wdata[31:16] = cmd_data_q;
                PI_REG_ADDR_LO:  stage_d.addr[15:0]   = cmd_data_q;
                PI_REG_ADDR_HI: begin
                    stage_d.addr[23:16] = cmd_data_q[7:0];
                    stage_d.size        = cmd_data_q[9:8];
                    stage_d.read        = cmd_data_q[10];
                    stage_d.fc          = cmd_data_q[13:11];
                    push                = 1'b1;
                end
                PI_REG_CTRL: begin
                    ctrl_d = ctrl_update(ctrl_q, cmd_data_q);
                    if (!cmd_data_q[CTRL_SET_BIT] && cmd_data_q[CTRL_OVF_CLR_BIT]) begin
                        ovf_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    // Outstanding entries remember whether they were reads so completions know
    // whether to capture read data; completions with nothing outstanding are ignored.
    always_comb begin
        done_en   = done_valid && !first_q && (out_cnt_q != 4'd0);
        out_rd_d  = out_rd_q;
        out_wp_d  = out_wp_q;
        out_rp_d  = out_rp_q;
        rdata_d   = rdata_q;
        done_ok_d = done_ok_q;
        first_d   = 1'b0;
        if (pop) begin
            out_rd_d[out_wp_q] = fifo_head.read;
            out_wp_d           = out_wp_q + 1'b1;
        end
        if (done_en) begin
            out_rp_d  = out_rp_q + 1'b1;
            done_ok_d = done_ok;
            if (out_rd_q[out_rp_q]) begin
                rdata_d = done_rdata;
            end
        end
        out_cnt_d = out_cnt_q + {3'd0, pop} - {3'd0, done_en};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q      <= '1;
            wr_strobe_q <= 1'b0;
            cmd_vld_q   <= 1'b0;
            stage_q     <= '0;
            ctrl_q      <= '0;
            ovf_q       <= 1'b0;
            rdata_q     <= '0;
            done_ok_q   <= 1'b0;
            first_q     <= 1'b1;
            out_cnt_q   <= 4'd0;
            out_wp_q    <= '0;
            out_rp_q    <= '0;
            out_rd_q    <= '0;
        end else begin
            sync_q      <= sync_d;
            wr_strobe_q <= wr_strobe_d;
            cmd_vld_q   <= cmd_vld_d;
            stage_q     <= stage_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
            rdata_q     <= rdata_d;
            done_ok_q   <= done_ok_d;
            first_q     <= first_d;
            out_cnt_q   <= out_cnt_d;
            out_wp_q    <= out_wp_d;
            out_rp_q    <= out_rp_d;
            out_rd_q    <= out_rd_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        cmd_a_q    <= cmd_a_d;
        cmd_data_q <= cmd_data_d;
    end

    assign req_addr      = fifo_head.addr;
    assign req_size      = fifo_head.size;
    assign req_read      = fifo_head.read;
    assign req_fc        = fifo_head.fc;
    assign req_wdata     = fifo_head.wdata;
    assign rdata         = rdata_q;
    assign pi_control    = ctrl_q;
    assign overflow      = ovf_q;
    assign fifo_count    = fifo_cnt;
    assign pi_req_active = (fifo_cnt != 4'd0) || (out_cnt_q != 4'd0);

endmodule
